uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of AXIS requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width fed to the UART transmitter.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, stall limit in cycles (used only under UART_ARB_TIMEOUT_EN).
REQ-004 SHALL have port aclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_tdata  input  N_SRC*DATA_W  requester data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port s_tvalid  input  N_SRC  per-source valid.
REQ-008 SHALL have port s_tlast  input  N_SRC  per-source end-of-packet.
REQ-009 SHALL have port s_tready  output  N_SRC  per-source ready.
REQ-010 SHALL have port m_tdata  output  DATA_W  data to the UART TX AXIS slave.
REQ-011 SHALL have port m_tvalid  output  1  valid to the UART TX.
REQ-012 SHALL have port m_tlast  output  1  end-of-packet of the granted source.
REQ-013 SHALL have port m_tready  input  1  ready from the UART TX.
REQ-014 SHALL have port grant_id  output  clog2(N_SRC)  index of the granted source (valid while busy=1).
REQ-015 SHALL have port busy  output  1  high while a packet is granted.

Function
REQ-016 SHALL arbitrate per packet, round-robin, with two states: IDLE and XFER.
REQ-017 In IDLE, when any s_tvalid is high, SHALL select the first requesting index after last_grant (wrapping from N_SRC-1 to 0), register it into grant_id, and enter XFER on the next edge.
REQ-018 In IDLE, SHALL drive all s_tready=0 and m_tvalid=0; arbitration latency SHALL be exactly 1 cycle from request to m_tvalid.
REQ-019 In XFER, SHALL combinationally route m_tdata/m_tvalid/m_tlast from source grant_id, s_tready[grant_id]=m_tready, all other s_tready=0; no added pipeline latency.
REQ-020 On a handshake (m_tvalid and m_tready) with m_tlast=1, SHALL set last_grant=grant_id and return to IDLE on that edge.
REQ-021 SHALL never switch grant mid-packet; a granted source deasserting s_tvalid only stalls the output (except REQ-027).
REQ-022 Simultaneous requests SHALL be served in rotation: with all N_SRC requesting single-beat packets continuously, grants SHALL cycle 0,1,...,N_SRC-1,0.
REQ-023 A single-beat packet (tlast on first beat) SHALL occupy exactly one XFER cycle when m_tready=1.
REQ-024 Requests from ungranted sources SHALL be held pending without data loss (their s_tready stays 0).

Reset
REQ-025 While aresetn=0, SHALL force state=IDLE, last_grant=N_SRC-1 (source 0 first), grant_id=0, busy=0, m_tvalid=0, s_tready=0, timeout counter=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately; after release, arbitration restarts from REQ-017 with no residual grant.

Configuration
REQ-027 With macro UART_ARB_TIMEOUT_EN defined, SHALL count consecutive XFER cycles with s_tvalid[grant_id]=0; at TIMEOUT_CYC SHALL return to IDLE, set last_grant=grant_id, and pulse output timeout (1 bit, 1 cycle); counter SHALL clear on any valid beat.
REQ-028 Without UART_ARB_TIMEOUT_EN, SHALL omit the counter and the timeout port; a stalled source holds the grant indefinitely.

Structure
REQ-029 SHALL place the state encoding (IDLE, XFER) and the default TIMEOUT_CYC constant in shared package uart_arb_pkg.
REQ-030 SHALL implement round-robin selection in sub-module uart_rr_pick (inputs: request vector, last_grant; outputs: any, next index), purely combinational.

Verification
REQ-031 Reset mid-packet: assert aresetn=0 during beat 2 of a 4-beat packet from source 2 -> m_tvalid=0 and s_tready=0 same cycle, busy=0; after release, source 0 request granted first.
REQ-032 Round-robin: sources 0..3 each request continuously with 1-beat packets 0xA0..0xA3, m_tready=1 -> m_tdata sequence A0,A1,A2,A3,A0 with one IDLE cycle between beats.
REQ-033 No mid-packet switch: source 1 sends 3-beat packet 0x11,0x12,0x13 while source 0 requests -> all three source-1 bytes emitted contiguously before any 0x00-source byte; then grant_id=0.
REQ-034 Backpressure: m_tready=0 for 10 cycles during granted beat 0x55 -> m_tdata holds 0x55, s_tready[grant_id]=0, byte emitted once when m_tready returns high.
REQ-035 Timeout (macro defined, TIMEOUT_CYC=16): source 3 sends 1 beat without tlast then drops s_tvalid -> timeout pulses after 16 cycles, busy=0, pending source 0 granted next.
REQ-036 Timeout compiled out: same stimulus as REQ-035 -> grant stays on source 3 for 100+ cycles, busy=1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared state encoding and default constants for the UART TX arbiter.
// The optional stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester strictly after last_grant, wrapping.
// Purely combinational; last_grant itself is chosen only if it is the sole requester.
module uart_rr_pick #(
  parameter int N_SRC = 4,
  localparam int ID_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic             any,
  output logic [ID_W-1:0]  next_idx
);

  logic [ID_W-1:0] idx;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    any      = 1'b0;
    next_idx = '0;
    idx      = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % N_SRC);
      if (req[idx]) begin
        any      = 1'b1;
        next_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin arbiter of N AXIS sources onto one UART TX stream.
// Define UART_ARB_TIMEOUT_EN to add the stalled-source timeout and its port.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int ID_W = $clog2(N_SRC)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC-1:0]        s_tvalid,
  input  logic [N_SRC-1:0]        s_tlast,
  output logic [N_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [ID_W-1:0]         grant_id,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    busy
);

  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_n
    $error("uart_tx_arbiter: N_SRC must be 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_to
    $error("uart_tx_arbiter: TIMEOUT_CYC must be >= 2");
  end

  arb_state_t      state, state_nx;
  logic [ID_W-1:0] gid_nx;
  logic [ID_W-1:0] last_grant, last_nx;
  logic            any_req;
  logic [ID_W-1:0] pick;
  logic            xfer;

  uart_rr_pick #(
    .N_SRC(N_SRC)
  ) u_pick (
    .req       (s_tvalid),
    .last_grant(last_grant),
    .any       (any_req),
    .next_idx  (pick)
  );

  assign xfer = (state == XFER);
  assign busy = xfer;

  // Data path is a plain mux on the registered grant: no added latency.
  always_comb begin
    m_tdata  = s_tdata[grant_id*DATA_W +: DATA_W];
    m_tvalid = xfer & s_tvalid[grant_id];
    m_tlast  = xfer & s_tlast[grant_id];
    s_tready = '0;
    if (xfer) s_tready[grant_id] = m_tready;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  always_comb begin
    state_nx = state;
    gid_nx   = grant_id;
    last_nx  = last_grant;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_nx   = '0;
    timeout  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gid_nx   = pick;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (m_tvalid && m_tready && m_tlast) begin
          last_nx  = grant_id;
          state_nx = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Count consecutive cycles the granted source shows no beat.
        if (!m_tvalid) begin
          if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout  = 1'b1;
            last_nx  = grant_id;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_SRC - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nx;
      grant_id   <= gid_nx;
      last_grant <= last_nx;
`ifdef UART_ARB_TIMEOUT_EN
      cnt        <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random and directed packet traffic.
// Define UART_ARB_TIMEOUT_EN to exercise the stall timeout build.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [1:0]    grant_id;
  logic          busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic          timeout;
`endif

  uart_tx_arbiter #(
    .N_SRC(N),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_tready(m_tready),
    .grant_id(grant_id),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout (timeout),
`endif
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Beats still to drive, and beats still expected at the output.
  logic [8:0] tx_q[N][$];
  logic [8:0] exp_q[N][$];
  logic [7:0] out_log[$];
  int         out_cyc[$];
  int         cyc = 0;
  int         to_seen = 0;

  bit         gap_en = 0;
  bit         rand_rdy = 0;
  bit         rdy_fix = 0;
  logic [N-1:0] hs_smp = '0;

  logic [7:0] rr_exp[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
  logic [7:0] ns_exp[4] = '{8'h11, 8'h12, 8'h13, 8'h00};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic enq(input int s, input logic [7:0] d, input bit l);
    tx_q[s].push_back({l, d});
    exp_q[s].push_back({l, d});
  endtask

  function automatic bit qs_empty();
    for (int i = 0; i < N; i++)
      if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_qs();
    for (int i = 0; i < N; i++) begin
      tx_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic wait_drain(input int max);
    int c;
    c = 0;
    while ((!qs_empty() || busy) && c < max) begin
      @(negedge aclk);
      c++;
    end
    chk("drain_in_time", int'(c < max), 1);
  endtask

  task automatic wait_busy(input int max);
    int c;
    c = 0;
    @(negedge aclk);
    while (!busy && c < max) begin
      @(negedge aclk);
      c++;
    end
    chk("grant_in_time", int'(busy), 1);
  endtask

  task automatic pulse_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    clear_qs();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  always @(negedge aclk) hs_smp = s_tvalid & s_tready;

  // Source driver: AXIS-legal, holds a presented beat until accepted.
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_smp[i] && tx_q[i].size() > 0)
          void'(tx_q[i].pop_front());
        if (tx_q[i].size() == 0) begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end else begin
          if (!(s_tvalid[i] && !hs_smp[i]))
            s_tvalid[i] = !(gap_en && $urandom_range(0, 2) == 0);
          s_tdata[i*DW +: DW] = tx_q[i][0][7:0];
          s_tlast[i] = tx_q[i][0][8];
        end
      end
      m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end
  end

  // Monitor with reference model: packet-level round robin from last grant.
  initial begin
    bit         m_busy;
    int         m_src;
    int         m_last;
    int         m_stall;
    bit         hs;
    bit         f;
    int         j;
    logic [8:0] e;
`ifdef UART_ARB_TIMEOUT_EN
    bit         exp_to;
`endif
    m_busy = 0;
    m_src = 0;
    m_last = N - 1;
    m_stall = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_busy = 0;
        m_last = N - 1;
        m_stall = 0;
        chk("rst_m_tvalid", int'(m_tvalid), 0);
        chk("rst_s_tready", int'(s_tready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), 0);
      end else begin
        cyc++;
`ifdef UART_ARB_TIMEOUT_EN
        exp_to = 0;
`endif
        chk("busy", int'(busy), int'(m_busy));
        if (m_busy) begin
          hs = s_tvalid[m_src] && m_tready;
          chk("grant_id", int'(grant_id), m_src);
          chk("m_tvalid", int'(m_tvalid), int'(s_tvalid[m_src]));
          chk("s_tready", int'(s_tready), m_tready ? (1 << m_src) : 0);
          if (hs) begin
            if (exp_q[m_src].size() == 0) begin
              e = 9'h100;
              chk("beat_unexpected", m_src, -1);
            end else begin
              e = exp_q[m_src].pop_front();
              chk("beat_data", int'(m_tdata), int'(e[7:0]));
              chk("beat_last", int'(m_tlast), int'(e[8]));
            end
            out_log.push_back(m_tdata);
            out_cyc.push_back(cyc);
            m_stall = 0;
            if (e[8]) begin
              m_busy = 0;
              m_last = m_src;
            end
          end else if (!s_tvalid[m_src]) begin
            m_stall++;
`ifdef UART_ARB_TIMEOUT_EN
            if (m_stall == TO) begin
              exp_to = 1;
              to_seen++;
              m_busy = 0;
              m_last = m_src;
              m_stall = 0;
            end
`endif
          end else begin
            m_stall = 0;
          end
        end else begin
          chk("idle_m_tvalid", int'(m_tvalid), 0);
          chk("idle_s_tready", int'(s_tready), 0);
          f = 0;
          for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (!f && s_tvalid[j]) begin
              f = 1;
              m_src = j;
            end
          end
          if (f) begin
            m_busy = 1;
            m_stall = 0;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("timeout", int'(timeout), int'(exp_to));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c;
    int cnt55;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Random traffic, random gaps and backpressure.
    gap_en = 1;
    rand_rdy = 1;
    for (int p = 0; p < 60; p++) begin
      int s;
      int len;
      s = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        enq(s, 8'($urandom_range(0, 255)), b == len - 1);
      repeat ($urandom_range(0, 4)) @(posedge aclk);
      #1;
    end
    wait_drain(3000);

    // Rotation with all sources requesting.
    gap_en = 0;
    rand_rdy = 0;
    rdy_fix = 1;
    pulse_reset();
    out_log.delete();
    out_cyc.delete();
    enq(0, 8'hA0, 1);
    enq(0, 8'hA0, 1);
    enq(1, 8'hA1, 1);
    enq(2, 8'hA2, 1);
    enq(3, 8'hA3, 1);
    wait_drain(100);
    chk("rr_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk($sformatf("rr_seq%0d", i), int'(out_log[i]), int'(rr_exp[i]));
    for (int i = 0; i < 4 && i + 1 < out_cyc.size(); i++)
      chk($sformatf("rr_gap%0d", i), out_cyc[i+1] - out_cyc[i], 2);

    // No switch mid-packet.
    out_log.delete();
    @(posedge aclk);
    #1;
    enq(1, 8'h11, 0);
    enq(1, 8'h12, 0);
    enq(1, 8'h13, 1);
    wait_busy(20);
    @(posedge aclk);
    #1;
    enq(0, 8'h00, 1);
    wait_drain(100);
    chk("ns_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk($sformatf("ns_seq%0d", i), int'(out_log[i]), int'(ns_exp[i]));

    // Backpressure on a granted beat.
    out_log.delete();
    @(posedge aclk);
    #1;
    rdy_fix = 0;
    enq(2, 8'h55, 1);
    wait_busy(20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_m_tdata", int'(m_tdata), 8'h55);
      chk("bp_m_tvalid", int'(m_tvalid), 1);
      chk("bp_s_tready", int'(s_tready[2]), 0);
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    rdy_fix = 1;
    wait_drain(50);
    cnt55 = 0;
    foreach (out_log[i]) if (out_log[i] == 8'h55) cnt55++;
    chk("bp_emit_once", cnt55, 1);

    // Reset during beat 2 of a 4-beat packet.
    out_log.delete();
    @(posedge aclk);
    #1;
    enq(2, 8'h21, 0);
    enq(2, 8'h22, 0);
    enq(2, 8'h23, 0);
    enq(2, 8'h24, 1);
    n0 = out_log.size();
    c = 0;
    while (out_log.size() == n0 && c < 50) begin
      @(negedge aclk);
      c++;
    end
    chk("mid_beat1_seen", out_log.size(), n0 + 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    clear_qs();
    #1;
    chk("mid_rst_m_tvalid", int'(m_tvalid), 0);
    chk("mid_rst_s_tready", int'(s_tready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    enq(2, 8'h31, 1);
    enq(0, 8'h30, 1);
    wait_busy(20);
    chk("mid_first_grant", int'(grant_id), 0);
    wait_drain(50);

    // Granted source stalls mid-packet while source 0 waits.
    out_log.delete();
    @(posedge aclk);
    #1;
    enq(3, 8'h3F, 0);
    wait_busy(20);
    chk("to_grant3", int'(grant_id), 3);
    @(posedge aclk);
    #1;
    enq(0, 8'h0A, 1);
`ifdef UART_ARB_TIMEOUT_EN
    wait_drain(200);
    chk("timeout_seen", to_seen, 1);
    chk("to_src0_served", out_log.size(), 2);
`else
    repeat (110) @(negedge aclk);
    chk("hold_busy", int'(busy), 1);
    chk("hold_grant3", int'(grant_id), 3);
    chk("hold_src0_pending", out_log.size(), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
